pc_fetch: RTL and testbench

//  Program-counter and instruction-fetch stage. Issues one instruction-memory request at a time and

---
 rtl/alpha_pkg.sv | 16 +
 rtl/pc_fetch.sv | 152 +++++++++++++++
 tb/tb_pc_fetch.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/alpha_pkg.sv
// Shared definitions for the alpha fetch front end: widths, reset vector and fetch-state encoding.
package alpha_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    HOLD  = 3'd2,
    DROP  = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch.sv
// PC / instruction-fetch stage: one outstanding imem request, redirect on bSel|jmpEn with squash.
// Optional MISALIGN_TRAP_EN: a misaligned redirect target halts fetch and raises a sticky trap.
module pc_fetch #(
  parameter int unsigned     XLEN     = alpha_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(alpha_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bSel,
  input  logic            jmpEn,
  input  logic [XLEN-1:0] tgtAddr,
  output logic            imReq,
  output logic [XLEN-1:0] imAddr,
  input  logic            imGnt,
  input  logic            imValid,
  input  logic [31:0]     imData,
  output logic            instValid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] instPc,
`ifdef MISALIGN_TRAP_EN
  output logic            misAlign,
  output logic [XLEN-1:0] misAddr,
`endif
  input  logic            decReady
);

  import alpha_pkg::*;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] reqpc_q, reqpc_d;
  logic [31:0]     instr_q, instr_d;
  logic            req_q;
  logic            hold_q;
  logic            redirect;
  logic [XLEN-1:0] tgt_aligned;

`ifdef MISALIGN_TRAP_EN
  logic            mis_q, mis_d;
  logic [XLEN-1:0] misaddr_q, misaddr_d;
  logic            trap;

  assign trap = redirect && (tgtAddr[1:0] != 2'b00);
`else
  logic unused_tgt_lsb;

  // Low target bits are simply dropped when the trap is not built.
  assign unused_tgt_lsb = ^tgtAddr[1:0];
`endif

  assign redirect    = bSel | jmpEn;
  assign tgt_aligned = {tgtAddr[XLEN-1:2], 2'b00};

  // Next-state and datapath update; redirect wins over every other event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    reqpc_d = reqpc_q;
    instr_d = instr_q;
`ifdef MISALIGN_TRAP_EN
    mis_d     = mis_q;
    misaddr_d = misaddr_q;
`endif
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = tgt_aligned;
          state_d = imGnt ? DROP : FETCH;
        end else if (imGnt) begin
          reqpc_d = pc_q;
          pc_d    = pc_q + PC_STEP;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = tgt_aligned;
          state_d = imValid ? FETCH : DROP;
        end else if (imValid) begin
          instr_d = imData;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = tgt_aligned;
          state_d = FETCH;
        end else if (decReady) begin
          state_d = FETCH;
        end
      end
      DROP: begin
        // The stale response still retires the outstanding request even during a redirect.
        if (redirect) pc_d = tgt_aligned;
        if (imValid) state_d = FETCH;
      end
`ifdef MISALIGN_TRAP_EN
      HALT:    state_d = HALT;
`endif
      default: state_d = FETCH;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (trap && (state_q != HALT)) begin
      pc_d      = pc_q;
      state_d   = HALT;
      mis_d     = 1'b1;
      misaddr_d = tgtAddr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      reqpc_q <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b1;
      hold_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
      misaddr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      reqpc_q <= reqpc_d;
      instr_q <= instr_d;
      req_q   <= (state_d == FETCH);
      hold_q  <= (state_d == HOLD);
`ifdef MISALIGN_TRAP_EN
      mis_q     <= mis_d;
      misaddr_q <= misaddr_d;
`endif
    end
  end

  // No request is offered while reset is held.
  assign imReq     = req_q & ~rst;
  assign imAddr    = pc_q;
  assign instValid = hold_q;
  assign inst      = instr_q;
  assign instPc    = reqpc_q;
`ifdef MISALIGN_TRAP_EN
  assign misAlign  = mis_q;
  assign misAddr   = misaddr_q;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: cycle vector table plus hand sequences for trap and mid-run reset.
// Define MISALIGN_TRAP_EN to check the trap build.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        bSel, jmpEn, imGnt, imValid, decReady;
  logic [31:0] tgtAddr, imData;
  logic        imReq, instValid;
  logic [31:0] imAddr, inst, instPc;
`ifdef MISALIGN_TRAP_EN
  logic        misAlign;
  logic [31:0] misAddr;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .bSel      (bSel),
    .jmpEn     (jmpEn),
    .tgtAddr   (tgtAddr),
    .imReq     (imReq),
    .imAddr    (imAddr),
    .imGnt     (imGnt),
    .imValid   (imValid),
    .imData    (imData),
    .instValid (instValid),
    .inst      (inst),
    .instPc    (instPc),
`ifdef MISALIGN_TRAP_EN
    .misAlign  (misAlign),
    .misAddr   (misAddr),
`endif
    .decReady  (decReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        bsel;
    logic        jmp;
    logic [31:0] tgt;
    logic        gnt;
    logic        vld;
    logic [31:0] data;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  localparam logic [31:0] A0 = 32'h0000_0013, A1 = 32'h0040_0093, A2 = 32'h0080_0113;
  localparam logic [31:0] B0 = 32'h00C0_0193, C0 = 32'h0100_0213;
  localparam logic [31:0] STALE0 = 32'hDEAD_BEEF, STALE1 = 32'hBAD0_0001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic bs, input logic jp, input logic [31:0] tg,
                       input logic gn, input logic vl, input logic [31:0] dt, input logic rd);
    rst = r; bSel = bs; jmpEn = jp; tgtAddr = tg;
    imGnt = gn; imValid = vl; imData = dt; decReady = rd;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step_in(input logic r, input logic bs, input logic jp, input logic [31:0] tg,
                         input logic gn, input logic vl, input logic [31:0] dt, input logic rd);
    @(negedge clk);
    drive(r, bs, jp, tg, gn, vl, dt, rd);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    // Test 1-5 table: {bsel,jmp,tgt,gnt,vld,data,rdy, e_req,e_addr,e_iv,e_inst,e_pc}
    vt.push_back('{0,0,32'h0,1,0,32'h0,0,   1,32'h0,0,32'h0,32'h0});
    vt.push_back('{0,0,32'h0,0,1,A0,0,      0,32'h4,0,32'h0,32'h0});
    vt.push_back('{0,0,32'h0,0,0,32'h0,1,   0,32'h4,1,A0,32'h0});
    vt.push_back('{0,0,32'h0,1,0,32'h0,0,   1,32'h4,0,A0,32'h0});
    vt.push_back('{0,0,32'h0,0,1,A1,0,      0,32'h8,0,A0,32'h4});
    vt.push_back('{0,0,32'h0,0,0,32'h0,1,   0,32'h8,1,A1,32'h4});
    vt.push_back('{0,0,32'h0,1,0,32'h0,0,   1,32'h8,0,A1,32'h4});
    vt.push_back('{0,0,32'h0,0,1,A2,0,      0,32'hC,0,A1,32'h8});
    vt.push_back('{0,0,32'h0,0,0,32'h0,1,   0,32'hC,1,A2,32'h8});
    vt.push_back('{0,0,32'h0,1,0,32'h0,0,   1,32'hC,0,A2,32'h8});
    vt.push_back('{1,0,32'h100,0,0,32'h0,0, 0,32'h10,0,A2,32'hC});
    vt.push_back('{0,0,32'h0,0,0,32'h0,0,   0,32'h100,0,A2,32'hC});
    vt.push_back('{0,0,32'h0,0,1,STALE0,0,  0,32'h100,0,A2,32'hC});
    vt.push_back('{0,0,32'h0,1,0,32'h0,0,   1,32'h100,0,A2,32'hC});
    vt.push_back('{0,0,32'h0,0,1,B0,0,      0,32'h104,0,A2,32'h100});
    for (int k = 0; k < 5; k++)
      vt.push_back('{0,0,32'h0,1,0,32'h0,0, 0,32'h104,1,B0,32'h100});
    vt.push_back('{0,1,32'h40,0,0,32'h0,0,  0,32'h104,1,B0,32'h100});
    vt.push_back('{0,0,32'h0,1,0,32'h0,0,   1,32'h40,0,B0,32'h100});
    vt.push_back('{1,0,32'h200,0,1,STALE1,0,0,32'h44,0,B0,32'h40});
    vt.push_back('{0,0,32'h0,0,0,32'h0,0,   1,32'h200,0,B0,32'h40});
    vt.push_back('{1,0,32'h300,1,0,32'h0,0, 1,32'h200,0,B0,32'h40});
    vt.push_back('{0,0,32'h0,0,1,STALE0,0,  0,32'h300,0,B0,32'h40});
    vt.push_back('{0,1,32'hFFFF_FFFC,0,0,32'h0,0, 1,32'h300,0,B0,32'h40});
    vt.push_back('{0,0,32'h0,1,0,32'h0,0,   1,32'hFFFF_FFFC,0,B0,32'h40});
    vt.push_back('{0,0,32'h0,0,1,C0,0,      0,32'h0,0,B0,32'hFFFF_FFFC});
    vt.push_back('{0,0,32'h0,0,0,32'h0,1,   0,32'h0,1,C0,32'hFFFF_FFFC});
    vt.push_back('{0,0,32'h0,0,0,32'h0,0,   1,32'h0,0,C0,32'hFFFF_FFFC});

    // Reset: two cycles with rst held, request must stay low throughout.
    step_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("rst imReq", 32'(imReq), 32'h0);
    chk("rst instValid", 32'(instValid), 32'h0);
    chk("rst inst", inst, 32'h0);
    chk("rst instPc", instPc, 32'h0);
    chk("rst imAddr", imAddr, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("rst misAlign", 32'(misAlign), 32'h0);
    chk("rst misAddr", misAddr, 32'h0);
`endif

    foreach (vt[i]) begin
      step_in(1'b0, vt[i].bsel, vt[i].jmp, vt[i].tgt, vt[i].gnt, vt[i].vld, vt[i].data, vt[i].rdy);
      chk($sformatf("v%0d imReq", i), 32'(imReq), 32'(vt[i].e_req));
      chk($sformatf("v%0d imAddr", i), imAddr, vt[i].e_addr);
      chk($sformatf("v%0d instValid", i), 32'(instValid), 32'(vt[i].e_iv));
      chk($sformatf("v%0d inst", i), inst, vt[i].e_inst);
      chk($sformatf("v%0d instPc", i), instPc, vt[i].e_pc);
    end

    // Test 6: misaligned redirect target from FETCH at pc 0.
    step_in(1'b0, 1'b1, 1'b0, 32'h102, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis pre imReq", 32'(imReq), 32'h1);
    step_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
`ifdef MISALIGN_TRAP_EN
    chk("mis imReq", 32'(imReq), 32'h0);
    chk("mis misAlign", 32'(misAlign), 32'h1);
    chk("mis misAddr", misAddr, 32'h102);
    chk("mis instValid", 32'(instValid), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step_in(1'b0, 1'b1, 1'b0, 32'h80, 1'b1, 1'b1, 32'h0, 1'b1);
      chk($sformatf("halt%0d imReq", k), 32'(imReq), 32'h0);
      chk($sformatf("halt%0d misAddr", k), misAddr, 32'h102);
      chk($sformatf("halt%0d instValid", k), 32'(instValid), 32'h0);
    end
`else
    chk("mis imReq", 32'(imReq), 32'h1);
    chk("mis imAddr", imAddr, 32'h100);
`endif

    // Mid-run reset returns to FETCH at the reset vector.
    step_in(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("mrst imReq low", 32'(imReq), 32'h0);
    step_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("mrst imReq", 32'(imReq), 32'h1);
    chk("mrst imAddr", imAddr, 32'h0);
    chk("mrst instValid", 32'(instValid), 32'h0);
    chk("mrst inst", inst, 32'h0);
    chk("mrst instPc", instPc, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("mrst misAlign", 32'(misAlign), 32'h0);
    chk("mrst misAddr", misAddr, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
